mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive fetch-loss cycles before fetch is forced to win.
REQ-002 SHALL have parameter XLEN, default 32: address and data width.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port if_req_v  in  1  fetch read request valid.
REQ-006 SHALL have port if_req_addr  in  XLEN  fetch byte address (pc).
REQ-007 SHALL have port if_req_rdy  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rsp_v / if_rsp_data  out  1 / XLEN  fetch read data return.
REQ-009 SHALL have port ls_req_v / ls_req_we / ls_req_be  in  1 / 1 / 4  load-store request valid, write enable, byte enables.
REQ-010 SHALL have port ls_req_addr / ls_req_wdata  in  XLEN / XLEN  load-store address, write data.
REQ-011 SHALL have port ls_req_rdy  out  1  load-store request accepted this cycle.
REQ-012 SHALL have port ls_rsp_v / ls_rsp_data  out  1 / XLEN  load data return.
REQ-013 SHALL have port flush  in  1  pipeline redirect (branch/jump taken in X).
REQ-014 SHALL have port mem_v / mem_we / mem_be  out  1 / 1 / 4  single memory port command.
REQ-015 SHALL have port mem_addr / mem_wdata  out  XLEN / XLEN  memory address, write data.
REQ-016 SHALL have port mem_rdata  in  XLEN  read data, valid exactly one cycle after a read command.

Function
REQ-017 SHALL grant at most one requester per cycle; memory is always ready, so grant equals accept.
REQ-018 SHALL grant load-store over fetch when both valid, unless starve_cnt == STARVE_MAX, then fetch wins.
REQ-019 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle if_req_v=1 and fetch not granted; clear when fetch granted or if_req_v=0.
REQ-020 SHALL hold if_req_rdy=0 whenever flush=1; ls arbitration unaffected by flush.
REQ-021 mem_* SHALL be a combinational mux of the granted request; mem_v=0 and other mem_* = 0 when no grant; fetch drives mem_we=0, mem_be=4'hF.
REQ-022 SHALL keep a registered response state rsp_src in {NONE, IF, LS}: next = IF on fetch grant, LS on load grant (ls_req_we=0), else NONE; writes produce no response.
REQ-023 if_rsp_v SHALL equal (rsp_src==IF) & !flush; ls_rsp_v SHALL equal (rsp_src==LS); rsp data = mem_rdata, 0 when not valid.
REQ-024 Read latency SHALL be exactly 1 cycle request-accept to response; back-to-back reads SHALL sustain 1 per cycle.
REQ-025 A fetch response suppressed by flush SHALL be discarded, never replayed.
REQ-026 Requests with rdy=0 SHALL NOT be latched; requester holds or changes freely.

Reset
REQ-027 While reset=1: all rdy, rsp_v, mem_v = 0, mem_* = 0, no grants.
REQ-028 Reset SHALL clear starve_cnt to 0 and rsp_src to NONE; a response in flight at reset is dropped.
REQ-029 First grant SHALL be possible in the first cycle with reset=0.

Structure
REQ-030 Shared package SHALL hold rsp_src enum (NONE/IF/LS) and XLEN constant, reused by fetch and LSU.
REQ-031 Starvation counter SHALL be a sub-module mem_arb_starve_cnt (inputs: want, lose, win; output: force); remainder flat.

Verification
REQ-032 Fetch only, addr 0x0,0x4,0x8 consecutive -> mem_addr same cycles, if_rsp_v each following cycle with mem_rdata.
REQ-033 Both valid 5 cycles, STARVE_MAX=3 -> ls,ls,ls,if,ls granted; starve_cnt 1,2,3,0,1.
REQ-034 Load at 0x100 then store at 0x104 (be=4'h3) -> ls_rsp_v once, one cycle after load; none for store; mem_be=4'h3.
REQ-035 Fetch granted cycle t, flush=1 at t+1 -> if_rsp_v=0 at t+1, if_req_rdy=0 at t+1, no later replay.
REQ-036 reset asserted cycle after a load grant -> ls_rsp_v=0, all outputs 0; first request after release granted immediately.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter and its requesters
// (fetch and load-store unit).
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_LS   = 2'd2
    } rsp_src_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Fetch starvation counter: counts consecutive cycles fetch wants the port but
// loses it, and raises o_force once the count reaches STARVE_MAX.
module mem_arb_starve_cnt #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_want,
    input  logic i_lose,
    input  logic i_win,
    output logic o_force
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;

    // Saturating loss counter; any win or idle fetch cycle restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_want || i_win) begin
            r_cnt <= '0;
        end else if (i_lose && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_force = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load-store requests onto one always-ready memory port
// and routes the one-cycle-latency read data back to the right requester.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int XLEN       = mem_port_arbiter_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_v,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_req_rdy,
    output logic            if_rsp_v,
    output logic [XLEN-1:0] if_rsp_data,
    input  logic            ls_req_v,
    input  logic            ls_req_we,
    input  logic [3:0]      ls_req_be,
    input  logic [XLEN-1:0] ls_req_addr,
    input  logic [XLEN-1:0] ls_req_wdata,
    output logic            ls_req_rdy,
    output logic            ls_rsp_v,
    output logic [XLEN-1:0] ls_rsp_data,
    input  logic            flush,
    output logic            mem_v,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    import mem_port_arbiter_pkg::*;

    logic     w_force;
    logic     w_if_gnt;
    logic     w_ls_gnt;
    logic     w_if_rsp;
    logic     w_ls_rsp;
    rsp_src_e r_rsp_src;
    rsp_src_e w_rsp_src_nxt;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .i_want  (if_req_v),
        .i_lose  (if_req_v & ~w_if_gnt),
        .i_win   (w_if_gnt),
        .o_force (w_force)
    );

    // Grant selection: load-store first unless fetch has starved; flush blocks fetch only.
    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (reset) begin
            w_if_gnt = 1'b0;
            w_ls_gnt = 1'b0;
        end else begin
            w_if_gnt = if_req_v & ~flush & (~ls_req_v | w_force);
            w_ls_gnt = ls_req_v & ~w_if_gnt;
        end
    end

    assign if_req_rdy = w_if_gnt;
    assign ls_req_rdy = w_ls_gnt;

    // Memory command mux of the granted requester.
    always_comb begin
        mem_v     = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_v    = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_req_addr;
        end else if (w_ls_gnt) begin
            mem_v     = 1'b1;
            mem_we    = ls_req_we;
            mem_be    = ls_req_be;
            mem_addr  = ls_req_addr;
            mem_wdata = ls_req_wdata;
        end else begin
            mem_v = 1'b0;
        end
    end

    // Owner of next cycle's read data; stores return nothing.
    always_comb begin
        w_rsp_src_nxt = RSP_NONE;
        if (w_if_gnt) begin
            w_rsp_src_nxt = RSP_IF;
        end else if (w_ls_gnt && !ls_req_we) begin
            w_rsp_src_nxt = RSP_LS;
        end else begin
            w_rsp_src_nxt = RSP_NONE;
        end
    end

    // Response-source register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_src <= RSP_NONE;
        end else begin
            r_rsp_src <= w_rsp_src_nxt;
        end
    end

    // A flushed fetch return is simply dropped; reset also kills anything in flight.
    always_comb begin
        w_if_rsp = 1'b0;
        w_ls_rsp = 1'b0;
        if (reset) begin
            w_if_rsp = 1'b0;
            w_ls_rsp = 1'b0;
        end else begin
            w_if_rsp = (r_rsp_src == RSP_IF) & ~flush;
            w_ls_rsp = (r_rsp_src == RSP_LS);
        end
    end

    assign if_rsp_v    = w_if_rsp;
    assign ls_rsp_v    = w_ls_rsp;
    assign if_rsp_data = w_if_rsp ? mem_rdata : '0;
    assign ls_rsp_data = w_ls_rsp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected read returns
// into a scoreboard queue, a negedge monitor pops and checks them.
module tb_mem_port_arbiter;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_IF   = 2'd1;
    localparam logic [1:0] P_LS   = 2'd2;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_v;
    logic [31:0] if_req_addr;
    logic        if_req_rdy;
    logic        if_rsp_v;
    logic [31:0] if_rsp_data;
    logic        ls_req_v;
    logic        ls_req_we;
    logic [3:0]  ls_req_be;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic        ls_req_rdy;
    logic        ls_rsp_v;
    logic [31:0] ls_rsp_data;
    logic        flush;
    logic        mem_v;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];
    exp_t mon_e;

    mem_port_arbiter #(.STARVE_MAX(3), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_v     (if_req_v),
        .if_req_addr  (if_req_addr),
        .if_req_rdy   (if_req_rdy),
        .if_rsp_v     (if_rsp_v),
        .if_rsp_data  (if_rsp_data),
        .ls_req_v     (ls_req_v),
        .ls_req_we    (ls_req_we),
        .ls_req_be    (ls_req_be),
        .ls_req_addr  (ls_req_addr),
        .ls_req_wdata (ls_req_wdata),
        .ls_req_rdy   (ls_req_rdy),
        .ls_rsp_v     (ls_rsp_v),
        .ls_rsp_data  (ls_rsp_data),
        .flush        (flush),
        .mem_v        (mem_v),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: read data for the previous cycle's read command.
    always @(posedge clk) begin
        mem_rdata <= (mem_v && !mem_we) ? mem_f(mem_addr) : 32'hDEAD_BEEF;
        cyc       <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic drv(input logic iv, input logic [31:0] ia, input logic lv, input logic lwe,
                       input logic [3:0] lbe, input logic [31:0] la, input logic [31:0] lwd,
                       input logic fl, input logic rs);
        if_req_v     = iv;
        if_req_addr  = ia;
        ls_req_v     = lv;
        ls_req_we    = lwe;
        ls_req_be    = lbe;
        ls_req_addr  = la;
        ls_req_wdata = lwd;
        flush        = fl;
        reset        = rs;
    endtask

    task automatic step(input string nm, input logic e_ifr, input logic e_lsr, input logic e_mv,
                        input logic e_we, input logic [3:0] e_be, input logic [31:0] e_addr,
                        input logic [31:0] e_wd, input logic [1:0] push, input logic rsp0);
        exp_t e;
        @(negedge clk);
        chk({nm, "_ctl"}, {if_req_rdy, ls_req_rdy, mem_v, mem_we, mem_be},
            {e_ifr, e_lsr, e_mv, e_we, e_be});
        chk({nm, "_addr"}, mem_addr, e_addr);
        chk({nm, "_wdata"}, mem_wdata, e_wd);
        if (rsp0) begin
            chk({nm, "_rsp_v"}, {if_rsp_v, ls_rsp_v}, 2'b00);
        end
        if (push != P_NONE) begin
            e.src  = (push == P_IF) ? 2'b10 : 2'b01;
            e.data = mem_f(e_addr);
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every presented return must match the oldest expectation.
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_rsp actual=none required=src%0b in cycle %0d", mon_e.src, mon_e.cyc);
        end
        if (if_rsp_v || ls_rsp_v) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rsp actual if=%0b ls=%0b required=none (cycle %0d)",
                         if_rsp_v, ls_rsp_v, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_src", {if_rsp_v, ls_rsp_v}, mon_e.src);
                chk("rsp_cycle", cyc, mon_e.cyc);
                chk("rsp_data", if_rsp_v ? if_rsp_data : ls_rsp_data, mon_e.data);
            end
        end
        chk("rsp_idle_data", {(if_rsp_v ? 32'h0 : if_rsp_data), (ls_rsp_v ? 32'h0 : ls_rsp_data)}, 64'h0);
    end

    initial begin
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        // Reset holds everything quiet even with both requesters active.
        drv(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 1'b1);
        step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b1);
        step("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b1);

        // Back-to-back fetches, first one in the first cycle out of reset.
        drv(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("f0", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, P_IF, 1'b0);
        drv(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("f1", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, P_IF, 1'b0);
        drv(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("f2", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, P_IF, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b0);

        // Contention: ls, ls, ls, then starved fetch is forced, then ls again.
        drv(1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, 1'b0);
        step("s1", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, P_LS, 1'b0);
        drv(1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b0, 1'b0);
        step("s2", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h204, 32'h0, P_LS, 1'b0);
        drv(1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h208, 32'h0, 1'b0, 1'b0);
        step("s3", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h208, 32'h0, P_LS, 1'b0);
        drv(1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h20C, 32'h0, 1'b0, 1'b0);
        step("s4", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, P_IF, 1'b0);
        step("s5", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20C, 32'h0, P_LS, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b0);

        // Load returns data, partial store returns nothing.
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0);
        step("ld", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, P_LS, 1'b0);
        drv(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h104, 32'h1234_5678, 1'b0, 1'b0);
        step("st", 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h104, 32'h1234_5678, P_NONE, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b0);

        // Fetch then flush: return dropped, fetch blocked, ls still served.
        drv(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("fl_t", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, P_NONE, 1'b0);
        drv(1'b1, 32'h304, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1'b1, 1'b0);
        step("fl_t1", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, P_LS, 1'b1);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("fl_t2", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b0);
        step("fl_t3", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b1);

        // Reset right after a load grant drops its return; release grants at once.
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0, 1'b0);
        step("rl_t", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, P_NONE, 1'b0);
        drv(1'b1, 32'h600, 1'b1, 1'b0, 4'hF, 32'h404, 32'h0, 1'b0, 1'b1);
        step("rl_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b1);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h404, 32'h0, 1'b0, 1'b0);
        step("rl_rel", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h404, 32'h0, P_LS, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("idle4", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b0);
        step("idle5", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, P_NONE, 1'b0);

        chk("scoreboard_empty", q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
